// File: rtl/fetch_stage.sv
// Pipelined instruction fetch front end: req/gnt/rvalid memory port, prefetch FIFO, redirect flush.
// Optional same-cycle response bypass when the FIFO is empty: define FETCH_BYPASS_EN.
module fetch_stage #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    INSTR_WIDTH     = 32,
  parameter int                    FIFO_DEPTH      = 4,
  parameter int                    MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR       = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          instr_req_o,
  output logic [ADDR_WIDTH-1:0]         instr_addr_o,
  input  logic                          instr_gnt_i,
  input  logic                          instr_rvalid_i,
  input  logic [INSTR_WIDTH-1:0]        instr_rdata_i,
  input  logic                          redirect_i,
  input  logic [ADDR_WIDTH-1:0]         redirect_addr_i,
  output logic                          instr_valid_o,
  input  logic                          instr_ready_i,
  output logic [INSTR_WIDTH-1:0]        instr_o,
  output logic [ADDR_WIDTH-1:0]         instr_pc_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]    MAX_OUT_C = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W:0]      DEPTH_C   = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] INC     = ADDR_WIDTH'(4);

  logic [ADDR_WIDTH-1:0]  addr_q, addr_d, rsp_pc_q, rsp_pc_d, tgt_q, tgt_d;
  logic                   pend_q, pend_d, run_q;
  logic [CNT_W-1:0]       outst_q, outst_d, disc_q, disc_d, count_q, count_d;
  logic [PTR_W-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [INSTR_WIDTH-1:0] mem_instr [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  mem_pc    [FIFO_DEPTH];

  logic [ADDR_WIDTH-1:0] redirect_tgt;
  logic gnt_fire, rsp_live, rsp_drop, rsp_accept, fifo_valid;
  logic bypass, bypass_take, push, pop;

  // Requests only start once reset has been released for a full cycle.
  assign instr_req_o  = run_q && (({1'b0, outst_q} + {1'b0, count_q}) < DEPTH_C)
                        && (outst_q < MAX_OUT_C);
  assign instr_addr_o = addr_q;
  assign redirect_tgt = redirect_addr_i & ~ADDR_WIDTH'(3);

  assign gnt_fire   = instr_req_o && instr_gnt_i;
  // Responses with nothing outstanding belong to requests killed by reset.
  assign rsp_live   = instr_rvalid_i && (outst_q != '0);
  assign rsp_drop   = disc_q != '0;
  assign rsp_accept = rsp_live && !rsp_drop && !redirect_i;
  assign fifo_valid = count_q != '0;

`ifdef FETCH_BYPASS_EN
  assign bypass = !fifo_valid && rsp_accept;
`else
  assign bypass = 1'b0;
`endif
  assign bypass_take = bypass && instr_ready_i;
  assign push        = rsp_accept && !bypass_take;
  assign pop         = fifo_valid && instr_ready_i && !redirect_i;

  assign instr_valid_o = fifo_valid || bypass;
  assign instr_o       = fifo_valid ? mem_instr[rd_q] : (bypass ? instr_rdata_i : '0);
  assign instr_pc_o    = fifo_valid ? mem_pc[rd_q]    : (bypass ? rsp_pc_q      : '0);
  assign fifo_count_o  = count_q;

  always_comb begin
    outst_d  = outst_q + CNT_W'(gnt_fire) - CNT_W'(rsp_live);
    disc_d   = disc_q;
    addr_d   = addr_q;
    pend_d   = pend_q;
    tgt_d    = tgt_q;
    rsp_pc_d = rsp_pc_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

    if (rsp_live && rsp_drop) disc_d = disc_q - 1'b1;
    if (rsp_accept) rsp_pc_d = rsp_pc_q + INC;
    if (push) wr_d = wr_q + PTR_W'(1);
    if (pop) rd_d = rd_q + PTR_W'(1);

    // A request held across a redirect completes on the old address and is then stale.
    if (gnt_fire) begin
      if (pend_q) begin
        addr_d = tgt_q;
        pend_d = 1'b0;
        disc_d = disc_d + 1'b1;
      end else begin
        addr_d = addr_q + INC;
      end
    end

    if (redirect_i) begin
      count_d  = '0;
      wr_d     = '0;
      rd_d     = '0;
      disc_d   = outst_d;
      rsp_pc_d = redirect_tgt;
      if (instr_req_o && !instr_gnt_i) begin
        pend_d = 1'b1;
        tgt_d  = redirect_tgt;
      end else begin
        addr_d = redirect_tgt;
        pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q    <= 1'b0;
      addr_q   <= BOOT_ADDR;
      rsp_pc_q <= BOOT_ADDR;
      tgt_q    <= BOOT_ADDR;
      pend_q   <= 1'b0;
      outst_q  <= '0;
      disc_q   <= '0;
      count_q  <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
    end else begin
      run_q    <= 1'b1;
      addr_q   <= addr_d;
      rsp_pc_q <= rsp_pc_d;
      tgt_q    <= tgt_d;
      pend_q   <= pend_d;
      outst_q  <= outst_d;
      disc_q   <= disc_d;
      count_q  <= count_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
    end
  end

  // Storage needs no reset: contents are only visible while count_q says valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_q] <= instr_rdata_i;
      mem_pc[wr_q]    <= rsp_pc_q;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) assert (!(push && !pop && count_q == DEPTH_C[CNT_W-1:0]));
  end
`endif
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Parametrised instruction fetch front end for the toothless core. It replaces the single-cycle ROM lookup with a pipelined request/grant/response instruction-memory interface and a prefetch FIFO. Each FIFO entry holds an instruction and its PC, and entries are handed to decode/execute over a valid/ready handshake. The block accepts redirects from the control unit on jumps and taken branches: it flushes stale entries and discards in-flight responses.

Parameters:
ADDR_WIDTH, 32, fetch address / PC width
INSTR_WIDTH, 32, instruction word width
FIFO_DEPTH, 4, prefetch FIFO entries; power of two, >= 2
MAX_OUTSTANDING, 2, max granted-but-unanswered requests; 1..FIFO_DEPTH
BOOT_ADDR, 32'h0000_0000, first fetch address after reset; word aligned

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
instr_req_o  out  1  fetch request to instruction memory
instr_addr_o  out  ADDR_WIDTH  fetch address, bits[1:0] always 0
instr_gnt_i  in  1  memory accepts request this cycle
instr_rvalid_i  in  1  response valid; responses return in request order
instr_rdata_i  in  INSTR_WIDTH  response instruction
redirect_i  in  1  flush and restart fetch (jump / taken branch)
redirect_addr_i  in  ADDR_WIDTH  new fetch address; bits[1:0] ignored, forced to 0
instr_valid_o  out  1  head entry valid
instr_ready_i  in  1  consumer takes head entry
instr_o  out  INSTR_WIDTH  head instruction; 0 when empty
instr_pc_o  out  ADDR_WIDTH  head PC; 0 when empty
fifo_count_o  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset: instr_req_o=0, instr_addr_o=BOOT_ADDR, instr_valid_o=0, instr_o=0, instr_pc_o=0, fifo_count_o=0. FIFO, outstanding counter and discard counter are cleared. Reset mid-transaction drops everything; responses arriving after reset release are not counted and are ignored.
- Credit rule: instr_req_o=1 when (outstanding + fifo_count) < FIFO_DEPTH and outstanding < MAX_OUTSTANDING. The first request is asserted in the first cycle after reset deassertion.
- Handshake: a request completes when instr_req_o && instr_gnt_i. After that, instr_addr_o += 4 (wraps modulo 2^ADDR_WIDTH) and outstanding += 1.
- Stability: once asserted, instr_req_o and instr_addr_o hold until gnt, even across a redirect.
- Response: instr_rvalid_i decrements outstanding. If the discard counter > 0, it decrements and the data is dropped. Otherwise {rdata, pc} is written at the tail. The pc comes from a companion PC register that advances by 4 per accepted response.
- Pop: when instr_valid_o && instr_ready_i, the head advances. Simultaneous push and pop leaves the count unchanged. Push while full cannot occur under the credit rule; assert in simulation.
- Redirect (registered, effective next cycle):
  - FIFO is flushed and the same-cycle pop is ignored.
  - discard = outstanding after this cycle's rvalid/gnt accounting, including a request granted in the redirect cycle.
  - A response arriving in the redirect cycle is dropped.
  - Fetch address and response PC are loaded with {redirect_addr_i[ADDR_WIDTH-1:2], 2'b00}.
  - If a request is pending without gnt, it stays on the old address until gnt, is then counted as discard, and the new address is issued the cycle after.
  - Back-to-back redirects: the latest one wins; discard keeps accumulating correctly.
- Latency without the optional feature: gnt in cycle N, rvalid in N+1, instr_valid_o=1 in N+2.

Optional Feature:
FETCH_BYPASS_EN.
- Defined: when the FIFO is empty, discard==0 and instr_rvalid_i=1, the response appears on instr_o/instr_pc_o with instr_valid_o=1 in the same cycle. If instr_ready_i=1 it is consumed without being written; otherwise it is written normally.
- Undefined: no bypass; data always passes through the FIFO (1 extra cycle).

Test Plan:
- Reset release, memory grants every cycle, rvalid one cycle later, ready=1 -> addresses 0x0,0x4,0x8… issued back-to-back; instr_pc_o follows 0x0,0x4,…; first instr_valid_o 2 cycles after first gnt (1 with FETCH_BYPASS_EN).
- instr_ready_i=0 held, FIFO_DEPTH=4 -> exactly 4 requests granted, fifo_count_o=4, instr_req_o=0; ready=1 for one cycle -> one new request issued.
- gnt withheld 3 cycles -> instr_req_o and instr_addr_o stable throughout; advance by 4 only after gnt.
- 2 outstanding requests, redirect_i=1 with redirect_addr_i=0x103 -> FIFO empty next cycle, both old responses dropped, next fetch address 0x100, first delivered PC 0x100.
- Redirect in the same cycle as rvalid and gnt -> that rvalid dropped, granted request counted in discard, no stale instruction ever reaches instr_valid_o.
- Fetch address at 0xFFFF_FFFC with ADDR_WIDTH=32 -> next address 0x0000_0000; rst asserted mid-burst -> all outputs return to reset values asynchronously.
